serial_add_ctrl: RTL and testbench

Bit-serial add/subtract controller that sequences a single 1-bit full-adder cell (`a`, `b`, `cin` → `sum`, `carry`) across an N-bit operand pair, one bit per clock, LSB first. It latches operands on a start handshake and holds a carry flip-flop between bit slices. It publishes a registered N-bit result with carry and signed-overflow flags. It sits between a requesting datapath and the shared full-adder cell, trading latency for area.

---
 rtl/serial_add_ctrl_if.sv | 24 ++
 rtl/serial_add_ctrl.sv | 116 +++++++++++
 tb/tb_serial_add_ctrl.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/serial_add_ctrl_if.sv
// Request/result bundle between a requesting datapath and the bit-serial add/subtract controller.
// The master drives the request side and the slave publishes busy/done and the registered result.
interface serial_add_ctrl_if #(parameter int N = 8);
    logic         start;
    logic         op;
    logic [N-1:0] a_in;
    logic [N-1:0] b_in;
    logic         cin;
    logic         busy;
    logic         done;
    logic [N-1:0] sum_out;
    logic         carry_out;
    logic         ovf;

    modport master (
        output start, op, a_in, b_in, cin,
        input  busy, done, sum_out, carry_out, ovf
    );

    modport slave (
        input  start, op, a_in, b_in, cin,
        output busy, done, sum_out, carry_out, ovf
    );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract controller: one full-adder slice per clock, LSB first,
// with a registered N-bit result, carry-out and signed-overflow flag.
module serial_add_ctrl #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst,
    serial_add_ctrl_if.slave bus
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [1:0]    IDLE = 2'd0;
    localparam logic [1:0]    RUN  = 2'd1;
    localparam logic [1:0]    DONE = 2'd2;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    // The shared 1-bit cell; returns {carry, sum}.
    function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
        return {(a & b) | (a & c) | (b & c), a ^ b ^ c};
    endfunction

    logic [1:0]    state_r;
    logic [1:0]    state_nxt_s;
    logic [N-1:0]  a_sh_r;
    logic [N-1:0]  b_sh_r;
    logic [N-1:0]  s_sh_r;
    logic          c_reg_r;
    logic          c_msb_r;
    logic [CW-1:0] cnt_r;
    logic          busy_r;
    logic          done_r;
    logic [N-1:0]  sum_out_r;
    logic          carry_out_r;
    logic          ovf_r;
    logic          sum_s;
    logic          carry_s;
    logic          last_s;

    // Current bit slice through the full-adder cell.
    always_comb begin
        {carry_s, sum_s} = full_add(a_sh_r[0], b_sh_r[0], c_reg_r);
        last_s           = (cnt_r == LAST);
    end

    // Next-state decode; start only matters in IDLE.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.start) state_nxt_s = RUN;
                else           state_nxt_s = IDLE;
            end
            RUN: begin
                if (last_s) state_nxt_s = DONE;
                else        state_nxt_s = RUN;
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Datapath, FSM and registered outputs; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            a_sh_r      <= {N{1'b0}};
            b_sh_r      <= {N{1'b0}};
            s_sh_r      <= {N{1'b0}};
            c_reg_r     <= 1'b0;
            c_msb_r     <= 1'b0;
            cnt_r       <= {CW{1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            sum_out_r   <= {N{1'b0}};
            carry_out_r <= 1'b0;
            ovf_r       <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s == RUN);
            done_r  <= (state_nxt_s == DONE);
            case (state_r)
                IDLE: begin
                    if (bus.start) begin
                        // Subtract is a + ~b + 1, so the inversion and the +1 are folded into the load.
                        a_sh_r  <= bus.a_in;
                        b_sh_r  <= bus.op ? ~bus.b_in : bus.b_in;
                        c_reg_r <= bus.op ? 1'b1 : bus.cin;
                        cnt_r   <= {CW{1'b0}};
                    end
                end
                RUN: begin
                    s_sh_r  <= {sum_s, s_sh_r[N-1:1]};
                    a_sh_r  <= {1'b0, a_sh_r[N-1:1]};
                    b_sh_r  <= {1'b0, b_sh_r[N-1:1]};
                    c_reg_r <= carry_s;
                    cnt_r   <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
                    if (last_s) begin
                        c_msb_r     <= c_reg_r;
                        sum_out_r   <= {sum_s, s_sh_r[N-1:1]};
                        carry_out_r <= carry_s;
                        ovf_r       <= carry_s ^ c_reg_r;
                    end
                end
                DONE: begin
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.sum_out   = sum_out_r;
    assign bus.carry_out = carry_out_r;
    assign bus.ovf       = ovf_r;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: spec vectors, random ops against an
// arithmetic reference model, and hand-written collision / mid-run reset sequences.
module tb_serial_add_ctrl;
    localparam int N = 8;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    serial_add_ctrl_if #(.N(N)) bus ();

    serial_add_ctrl #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       op;
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] exp_sum;
        logic       exp_c;
        logic       exp_v;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed views of the operands.
    function automatic void model(input logic op, input logic [7:0] a, input logic [7:0] b,
                                  input logic cin, output logic [7:0] s, output logic c,
                                  output logic v);
        int ua;
        int ub;
        int sa;
        int sb;
        int r;
        int sr;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (op) begin
            r  = ua - ub;
            c  = (ua >= ub);
            sr = sa - sb;
        end else begin
            r  = ua + ub + int'(cin);
            c  = (r > 255);
            sr = sa + sb + int'(cin);
        end
        s = r[7:0];
        v = (sr > 127) || (sr < -128);
    endfunction

    // Issue one operation, scramble inputs while busy, and check timing and result.
    task automatic run_op(input string name, input logic op, input logic [7:0] a,
                          input logic [7:0] b, input logic cin, input logic [7:0] es,
                          input logic ec, input logic ev);
        int busy_cnt;
        int cyc;
        int overlap;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a_in  = a;
        bus.b_in  = b;
        bus.cin   = cin;
        @(negedge clk);
        bus.start = 1'b0;
        busy_cnt  = 0;
        cyc       = 0;
        overlap   = 0;
        while (!bus.done && cyc < N + 10) begin
            if (bus.busy) busy_cnt++;
            bus.a_in = 8'($urandom);
            bus.b_in = 8'($urandom);
            bus.op   = 1'($urandom);
            bus.cin  = 1'($urandom);
            @(negedge clk);
            cyc++;
        end
        if (bus.busy && bus.done) overlap = 1;
        chk({name, " done seen"}, {31'd0, bus.done}, 32'd1);
        chk({name, " busy cycles"}, busy_cnt, N);
        chk({name, " busy&done"}, overlap, 32'd0);
        chk({name, " sum"}, {24'd0, bus.sum_out}, {24'd0, es});
        chk({name, " carry"}, {31'd0, bus.carry_out}, {31'd0, ec});
        chk({name, " ovf"}, {31'd0, bus.ovf}, {31'd0, ev});
        @(negedge clk);
        chk({name, " done pulse"}, {31'd0, bus.done}, 32'd0);
    endtask

    initial begin
        logic [7:0] ms;
        logic       mc;
        logic       mv;
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rop;
        logic       rcin;
        int         dones;
        int         cyc;

        n_cmp = 0;
        n_bad = 0;
        vecs[0] = '{"add5a3c", 1'b0, 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1};
        vecs[1] = '{"addwrap", 1'b0, 8'hFF, 8'h01, 1'b1, 8'h01, 1'b1, 1'b0};
        vecs[2] = '{"sub1020", 1'b1, 8'h10, 8'h20, 1'b0, 8'hF0, 1'b0, 1'b0};
        vecs[3] = '{"sub8001", 1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1};

        // Reset with random inputs on the bus.
        rst       = 1'b1;
        bus.start = 1'($urandom);
        bus.op    = 1'($urandom);
        bus.a_in  = 8'($urandom);
        bus.b_in  = 8'($urandom);
        bus.cin   = 1'($urandom);
        repeat (2) @(negedge clk);
        rst       = 1'b0;
        bus.start = 1'b0;
        chk("rst busy", {31'd0, bus.busy}, 32'd0);
        chk("rst done", {31'd0, bus.done}, 32'd0);
        chk("rst sum", {24'd0, bus.sum_out}, 32'd0);
        chk("rst carry", {31'd0, bus.carry_out}, 32'd0);
        chk("rst ovf", {31'd0, bus.ovf}, 32'd0);
        dones = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.done || bus.busy) dones++;
        end
        chk("idle quiet", dones, 32'd0);

        for (int i = 0; i < 4; i++)
            run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin,
                   vecs[i].exp_sum, vecs[i].exp_c, vecs[i].exp_v);

        for (int i = 0; i < 20; i++) begin
            ra   = 8'($urandom);
            rb   = 8'($urandom);
            rop  = 1'($urandom);
            rcin = 1'($urandom);
            model(rop, ra, rb, rcin, ms, mc, mv);
            run_op($sformatf("rnd%0d", i), rop, ra, rb, rcin, ms, mc, mv);
        end

        // Collision: start held high through RUN and DONE with different operands.
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 1'b0;
        bus.cin   = 1'b0;
        bus.a_in  = 8'h01;
        bus.b_in  = 8'h01;
        @(negedge clk);
        bus.a_in  = 8'hAA;
        bus.b_in  = 8'h55;
        cyc = 0;
        while (!bus.done && cyc < N + 10) begin
            @(negedge clk);
            cyc++;
        end
        chk("coll done", {31'd0, bus.done}, 32'd1);
        chk("coll sum", {24'd0, bus.sum_out}, 32'h02);
        @(negedge clk);
        chk("coll no restart", {30'd0, bus.busy, bus.done}, 32'd0);
        @(negedge clk);
        bus.start = 1'b0;
        chk("coll accept", {31'd0, bus.busy}, 32'd1);
        cyc = 0;
        while (!bus.done && cyc < N + 10) begin
            @(negedge clk);
            cyc++;
        end
        chk("coll2 sum", {24'd0, bus.sum_out}, 32'hFF);
        @(negedge clk);

        // Mid-run reset: abort at bit 3, then confirm silence and a clean restart.
        bus.start = 1'b1;
        bus.op    = 1'b0;
        bus.cin   = 1'b0;
        bus.a_in  = 8'h0F;
        bus.b_in  = 8'h01;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mrst busy", {31'd0, bus.busy}, 32'd0);
        chk("mrst sum", {24'd0, bus.sum_out}, 32'd0);
        chk("mrst flags", {30'd0, bus.carry_out, bus.ovf}, 32'd0);
        dones = 0;
        repeat (N + 4) begin
            @(negedge clk);
            if (bus.done || bus.busy) dones++;
        end
        chk("mrst no done", dones, 32'd0);
        run_op("post rst", 1'b0, 8'h03, 8'h04, 1'b0, 8'h07, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
